// File: rtl/tc_detect_conditioner.sv
// Loop-sensor conditioner: per direction, synchronises the raw sensor, debounces
// presence, holds a vehicle request until that direction's green is seen, and counts its wait.
module tc_detect_channel #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  input  logic       green,
  output logic       detect,
  output logic [7:0] wait_cycles
);

  typedef enum logic [1:0] {IDLE, QUALIFY, LATCHED} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       wait_q, wait_next;
  logic             sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      wait_q <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      state  <= state_next;
      cnt    <= cnt_next;
      wait_q <= wait_next;
    end
  end

  // Own green overrides everything: the direction is being served, so any request is dropped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wait_next  = '0;
    if (green) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync2) begin
            state_next = QUALIFY;
            cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_next = '0;
          end
        end
        QUALIFY: begin
          if (!sync2) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt == LAST) begin
            state_next = LATCHED;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        LATCHED: begin
          state_next = LATCHED;
          wait_next  = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign detect      = (state == LATCHED);
  assign wait_cycles = wait_q;

endmodule

module tc_detect_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_NS_raw,
  input  logic       i_EW_raw,
  input  logic       i_NS_green,
  input  logic       i_EW_green,
  output logic       o_NS_vehicle_detect,
  output logic       o_EW_vehicle_detect,
  output logic [7:0] o_NS_wait,
  output logic [7:0] o_EW_wait
);

  tc_detect_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) ns_channel (
    .clk        (i_clk),
    .rst        (i_rst),
    .raw        (i_NS_raw),
    .green      (i_NS_green),
    .detect     (o_NS_vehicle_detect),
    .wait_cycles(o_NS_wait)
  );

  tc_detect_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) ew_channel (
    .clk        (i_clk),
    .rst        (i_rst),
    .raw        (i_EW_raw),
    .green      (i_EW_green),
    .detect     (o_EW_vehicle_detect),
    .wait_cycles(o_EW_wait)
  );

endmodule

// File: tb/tb_tc_detect_conditioner.sv
// Directed bench for tc_detect_conditioner at DEBOUNCE_CYCLES=8: reset, bounce,
// latch/serve, green suppression, wait saturation, green race and mid-latch reset.
module tb_tc_detect_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       ns_raw, ew_raw, ns_green, ew_green;
  logic       ns_det, ew_det;
  logic [7:0] ns_wait, ew_wait;

  int errors = 0;
  int checks = 0;

  tc_detect_conditioner #(.DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_NS_raw           (ns_raw),
    .i_EW_raw           (ew_raw),
    .i_NS_green         (ns_green),
    .i_EW_green         (ew_green),
    .o_NS_vehicle_detect(ns_det),
    .o_EW_vehicle_detect(ew_det),
    .o_NS_wait          (ns_wait),
    .o_EW_wait          (ew_wait)
  );

  always #5 clk = ~clk;

  // Advance one edge; afterwards outputs reflect that edge and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve both directions with sensors idle so every test starts from IDLE with empty syncs.
  task automatic settle();
    ns_raw = 0; ew_raw = 0; ns_green = 1; ew_green = 1;
    repeat (3) step();
    ns_green = 0; ew_green = 0;
    step();
  endtask

  task automatic test_reset();
    rst = 1; ns_raw = 1; ew_raw = 1; ns_green = 0; ew_green = 0;
    repeat (5) step();
    checks++;
    if ({ns_det, ew_det, ns_wait, ew_wait} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ns_det=%0b ew_det=%0b ns_wait=%0d ew_wait=%0d, want all 0",
               ns_det, ew_det, ns_wait, ew_wait);
    end
    rst = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (ns_det !== (i == 10) || ew_det !== (i == 10)) begin
        errors++;
        $display("[TB] FAIL reset_release_latency edge %0d: got ns=%0b ew=%0b, want %0b", i, ns_det, ew_det, i == 10);
      end
    end
  endtask

  task automatic test_bounce();
    logic [0:17] pattern;
    settle();
    pattern = 18'b111111101111111000;
    for (int i = 0; i < 18; i++) begin
      ew_raw = pattern[i];
      step();
      checks++;
      if (ew_det !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_no_detect step %0d: got %0b, want 0", i, ew_det);
      end
    end
    ew_raw = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (ew_det !== (i == 10)) begin
        errors++;
        $display("[TB] FAIL bounce_requalify edge %0d: got %0b, want %0b", i, ew_det, i == 10);
      end
    end
  endtask

  task automatic test_latch_serve();
    settle();
    ns_raw = 1;
    repeat (10) step();
    checks++;
    if (ns_det !== 1'b1 || ns_wait !== 8'd0) begin
      errors++;
      $display("[TB] FAIL latch_entry: got det=%0b wait=%0d, want det=1 wait=0", ns_det, ns_wait);
    end
    ns_raw = 0;
    for (int i = 1; i <= 19; i++) begin
      step();
      checks++;
      if (ns_det !== 1'b1) begin
        errors++;
        $display("[TB] FAIL latch_hold step %0d: got %0b, want 1", i, ns_det);
      end
    end
    checks++;
    if (ns_wait !== 8'd19) begin
      errors++;
      $display("[TB] FAIL latch_wait: got %0d, want 19", ns_wait);
    end
    ns_green = 1;
    step();
    checks++;
    if (ns_det !== 1'b0 || ns_wait !== 8'd0) begin
      errors++;
      $display("[TB] FAIL serve_clear: got det=%0b wait=%0d, want det=0 wait=0", ns_det, ns_wait);
    end
    ns_green = 0;
  endtask

  task automatic test_suppression();
    settle();
    ew_green = 1; ew_raw = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (ew_det !== 1'b0) begin
        errors++;
        $display("[TB] FAIL green_suppress step %0d: got %0b, want 0", i, ew_det);
      end
    end
    ew_green = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (ew_det !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL green_release edge %0d: got %0b, want %0b", i, ew_det, i == 8);
      end
    end
    checks++;
    if (ns_det !== 1'b0) begin
      errors++;
      $display("[TB] FAIL suppress_ns_independent: got %0b, want 0", ns_det);
    end
  endtask

  task automatic test_saturation();
    settle();
    ew_raw = 1;
    repeat (10) step();
    checks++;
    if (ew_det !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_latch: got %0b, want 1", ew_det);
    end
    ew_raw = 0;
    for (int i = 1; i <= 300; i++) begin
      ns_raw = ((i / 3) % 2) == 1;
      step();
      checks++;
      if (ns_det !== 1'b0 || ns_wait !== 8'd0) begin
        errors++;
        $display("[TB] FAIL sat_ns_independent step %0d: got det=%0b wait=%0d, want 0/0", i, ns_det, ns_wait);
      end
      if (i == 100 || i == 254 || i == 255 || i == 256 || i == 300) begin
        checks++;
        if (ew_wait !== ((i > 255) ? 8'd255 : 8'(i))) begin
          errors++;
          $display("[TB] FAIL sat_wait step %0d: got %0d, want %0d", i, ew_wait, (i > 255) ? 255 : i);
        end
      end
    end
    checks++;
    if (ew_det !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_detect_hold: got %0b, want 1", ew_det);
    end
  endtask

  task automatic test_green_race();
    settle();
    ns_raw = 1;
    repeat (9) step();
    ns_green = 1;
    step();
    checks++;
    if (ns_det !== 1'b0) begin
      errors++;
      $display("[TB] FAIL green_race: got %0b, want 0", ns_det);
    end
    ns_green = 0;
    ns_raw = 0;
  endtask

  task automatic test_reset_mid_latch();
    settle();
    ns_raw = 1;
    repeat (50) step();
    checks++;
    if (ns_det !== 1'b1 || ns_wait !== 8'd40) begin
      errors++;
      $display("[TB] FAIL midlatch_setup: got det=%0b wait=%0d, want det=1 wait=40", ns_det, ns_wait);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (ns_det !== 1'b0 || ns_wait !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midlatch_reset: got det=%0b wait=%0d, want det=0 wait=0", ns_det, ns_wait);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (ns_det !== (i == 10)) begin
        errors++;
        $display("[TB] FAIL midlatch_requalify edge %0d: got %0b, want %0b", i, ns_det, i == 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_latch_serve();
    test_suppression();
    test_saturation();
    test_green_race();
    test_reset_mid_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tc_detect_conditioner.md
# tc_detect_conditioner

Conditions the raw NS and EW loop-sensor inputs into the clean vehicle-detect requests consumed by the traffic-light controller. Per direction: synchronises the sensor, debounces presence, latches a qualified request until that direction is served (its green observed), and reports how long the request has waited. Sits directly upstream of the controller; its `o_*_vehicle_detect` outputs drive the controller's `NS_vehicle_detect` / `EW_vehicle_detect` inputs, and the controller's green lamps feed back as service acknowledgements.

## Interface
- DEBOUNCE_CYCLES, 8, consecutive synchronised-high samples required to qualify a request; legal range 2..2^CNT_W-1
- CNT_W, 4, width of each debounce counter
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_NS_raw  in  1  NS loop sensor, asynchronous, may bounce
- i_EW_raw  in  1  EW loop sensor, asynchronous, may bounce
- i_NS_green  in  1  NS green lamp from controller (service ack for NS)
- i_EW_green  in  1  EW green lamp from controller (service ack for EW)
- o_NS_vehicle_detect  out  1  latched NS request
- o_EW_vehicle_detect  out  1  latched EW request
- o_NS_wait  out  8  cycles the NS request has been latched, saturating
- o_EW_wait  out  8  cycles the EW request has been latched, saturating

## Operation
- Two identical, fully independent per-direction channels (X = NS or EW); no shared state.
- Synchroniser: 2-flop chain on i_X_raw; FSM sees only the second-flop output `sX`.
- FSM states: IDLE, QUALIFY, LATCHED. Debounce counter `cntX` (CNT_W bits).
- Own green i_X_green has priority over every other condition in every state: next state IDLE, cntX=0.
- IDLE: sX=1 -> QUALIFY, cntX=1; else stay, cntX=0.
- QUALIFY: sX=0 -> IDLE, cntX=0 (any single low sample restarts qualification). sX=1 and cntX==DEBOUNCE_CYCLES-1 -> LATCHED. sX=1 otherwise -> cntX+1.
- LATCHED: o_X_vehicle_detect=1; holds regardless of sX (vehicle may leave loop, request still stands). Exits only on own green or reset.
- o_X_vehicle_detect = (state==LATCHED), registered.
- Wait counter: 0 on entry to LATCHED; +1 each cycle in LATCHED; saturates at 255 (never wraps); forced 0 in IDLE/QUALIFY.
- Requests arriving while own green is high are never latched (vehicle is being served).
- Both greens high at once (illegal from controller): both channels held in IDLE, no error flagged.

## Timing
- Reset (i_rst=1 at an edge): sync flops 0, state IDLE, cntX=0, both detect outputs 0, both wait outputs 0. Applies mid-qualification and mid-latch alike; first evaluation of sensor is the edge after i_rst deasserts.
- Latency: i_X_raw high set up before edge k and held -> sX high after edge k+1 -> QUALIFY with cntX=1 after edge k+2 -> o_X_vehicle_detect high after edge k+DEBOUNCE_CYCLES+1 (k+9 at default).
- Detect clear: i_X_green high sampled at edge m -> detect and wait 0 after edge m (one-cycle response).
- Own green sampled at the same edge qualification would complete -> IDLE, detect stays 0.
- o_X_wait after edge j of LATCHED residency = j-1, capped at 255.
- Raw pulses shorter than DEBOUNCE_CYCLES synchronised cycles produce no detect.

## Test plan
- Reset: drive i_rst=1 with i_NS_raw=i_EW_raw=1 for 5 cycles -> all outputs 0; release -> NS/EW detect rise exactly 9 edges after first edge with i_rst=0 (DEBOUNCE_CYCLES=8).
- Bounce: i_EW_raw high 7 cycles, low 1, high 7 -> o_EW_vehicle_detect never asserts; then high 8 continuous -> asserts at edge k+9.
- Latch and serve: qualify NS, drop i_NS_raw, wait 20 cycles -> detect stays 1, o_NS_wait=19; assert i_NS_green -> detect and wait 0 after that edge.
- Served-direction suppression: i_EW_green=1, i_EW_raw=1 for 50 cycles -> o_EW_vehicle_detect stays 0; drop green -> detect rises 8 edges later (sync already full).
- Saturation and independence: latch EW, hold 300 cycles with no green while NS bounces -> o_EW_wait stops at 255, NS outputs unaffected by EW.
- Reset mid-latch: NS latched with o_NS_wait=40, pulse i_rst one cycle -> detect 0, wait 0 after that edge, re-qualification required.
